// File: rtl/adder_operand_sequencer.sv
// Operand/result sequencer for an external carry-ripple adder: loads A/B from a
// switch bus, waits for the ripple chain to settle on Run, then captures Sum/CO/overflow.
module adder_operand_sequencer #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load_A,
    input  logic             Load_B,
    input  logic             Run,
    input  logic             Accumulate,
    input  logic [WIDTH-1:0] Sum_in,
    input  logic             CO_in,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;
    localparam logic [3:0] CNT_LAST  = 4'(SETTLE_CYCLES - 1);

    // Two's-complement overflow: operands agree in sign but the sum does not.
    function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                        input logic signed [WIDTH-1:0] b,
                                        input logic signed [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    logic [0:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             load_a_hist_q, load_b_hist_q, run_hist_q;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             load_a_edge, load_b_edge, run_edge;

    assign load_a_edge = Load_A & ~load_a_hist_q;
    assign load_b_edge = Load_B & ~load_b_hist_q;
    assign run_edge    = Run & ~run_hist_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_a_edge) a_d = Din;
                if (load_b_edge) b_d = Din;
                // Operands loaded this cycle are in place well before capture.
                if (run_edge) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    result_d = Sum_in;
                    carry_d  = CO_in;
                    ovf_d    = signed_ovf(a_q, b_q, Sum_in);
                    if (Accumulate) a_d = Sum_in;
                    cnt_d    = 4'd0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // History registers reset high so a button held through reset never fires.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            load_a_hist_q <= 1'b1;
            load_b_hist_q <= 1'b1;
            run_hist_q    <= 1'b1;
            a_q           <= '0;
            b_q           <= '0;
            result_q      <= '0;
            carry_q       <= 1'b0;
            ovf_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            load_a_hist_q <= Load_A;
            load_b_hist_q <= Load_B;
            run_hist_q    <= Run;
            a_q           <= a_d;
            b_q           <= b_d;
            result_q      <= result_d;
            carry_q       <= carry_d;
            ovf_q         <= ovf_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign A_out    = a_q;
    assign B_out    = b_q;
    assign Result   = result_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Scoreboard bench for adder_operand_sequencer: stimulus pushes predicted captures,
// a negedge monitor pops them whenever Done is presented.
module tb_adder_operand_sequencer;

    localparam int W      = 16;
    localparam int SETTLE = 2;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic [W-1:0] Din;
    logic         Load_A, Load_B, Run, Accumulate;
    logic [W-1:0] Sum_in;
    logic         CO_in;
    logic [W-1:0] A_out, B_out, Result;
    logic         Carry, Overflow, Busy, Done;

    always #5 Clk = ~Clk;

    // Behavioural ripple adder closing the loop around the sequencer.
    assign {CO_in, Sum_in} = {1'b0, A_out} + {1'b0, B_out};

    adder_operand_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Din(Din), .Load_A(Load_A), .Load_B(Load_B),
        .Run(Run), .Accumulate(Accumulate), .Sum_in(Sum_in), .CO_in(CO_in),
        .A_out(A_out), .B_out(B_out), .Result(Result), .Carry(Carry),
        .Overflow(Overflow), .Busy(Busy), .Done(Done)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        logic [W-1:0] a;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           busy_cnt = 0;
    logic [W-1:0] model_a  = '0;
    logic [W-1:0] model_b  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    // Reference: integer arithmetic on the operand values, no bit-level formula.
    function automatic exp_t predict(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic acc);
        exp_t        e;
        int unsigned u;
        int          s;
        shortint     sa, sbv;
        u    = int'(a) + int'(b);
        sa   = a;
        sbv  = b;
        s    = int'(sa) + int'(sbv);
        e.res = u[W-1:0];
        e.c   = (u > 32'd65535);
        e.o   = (s > 32767) || (s < -32768);
        e.a   = acc ? u[W-1:0] : a;
        return e;
    endfunction

    // Monitor: compare each Done against the oldest prediction and the Busy width.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            busy_cnt = 0;
        end else begin
            if (Done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("result", 32'(Result), 32'(mon_e.res));
                    check("carry", 32'(Carry), 32'(mon_e.c));
                    check("overflow", 32'(Overflow), 32'(mon_e.o));
                    check("a_after", 32'(A_out), 32'(mon_e.a));
                    check("busy_width", busy_cnt, SETTLE);
                end
                busy_cnt = 0;
            end
            if (Busy) busy_cnt++;
        end
    end

    task automatic load_a(input logic [W-1:0] v);
        @(posedge Clk); #1 Din = v; Load_A = 1'b1;
        @(posedge Clk); #1 Load_A = 1'b0;
        model_a = v;
    endtask

    task automatic load_b(input logic [W-1:0] v);
        @(posedge Clk); #1 Din = v; Load_B = 1'b1;
        @(posedge Clk); #1 Load_B = 1'b0;
        model_b = v;
    endtask

    task automatic load_ab(input logic [W-1:0] v);
        @(posedge Clk); #1 Din = v; Load_A = 1'b1; Load_B = 1'b1;
        @(posedge Clk); #1 Load_A = 1'b0; Load_B = 1'b0;
        model_a = v;
        model_b = v;
    endtask

    task automatic start_run(input logic acc);
        exp_t e;
        e = predict(model_a, model_b, acc);
        sb.push_back(e);
        model_a = e.a;
        @(posedge Clk); #1 Accumulate = acc; Run = 1'b1;
        @(posedge Clk); #1 Run = 1'b0;
    endtask

    task automatic run_wait(input logic acc);
        start_run(acc);
        repeat (SETTLE + 3) @(posedge Clk);
        #1;
    endtask

    task automatic back_to_back(input logic acc);
        start_run(acc);
        repeat (SETTLE - 1) @(posedge Clk);
        start_run(acc);
        repeat (SETTLE + 3) @(posedge Clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        Reset_n = 1'b0; Din = 16'h5555; Load_A = 1'b1; Load_B = 1'b0;
        Run = 1'b1; Accumulate = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        // Buttons held through reset release must not fire
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            check("held_busy", 32'(Busy), 32'd0);
            check("held_done", 32'(Done), 32'd0);
            check("held_a", 32'(A_out), 32'd0);
        end
        check("rst_result", 32'(Result), 32'd0);
        check("rst_flags", {30'd0, Carry, Overflow}, 32'd0);
        Run = 1'b0; Load_A = 1'b0;

        load_a(16'h1234); load_b(16'h0FF1); run_wait(1'b0);
        check("basic_sum", 32'(Result), 32'h2225);
        check("basic_flags", {30'd0, Carry, Overflow}, 32'd0);

        load_a(16'hFFFF); load_b(16'h0001); run_wait(1'b0);
        check("wrap_sum", 32'(Result), 32'h0000);
        check("wrap_flags", {30'd0, Carry, Overflow}, 32'b10);
        load_a(16'h7FFF); run_wait(1'b0);
        check("ovf_sum", 32'(Result), 32'h8000);
        check("ovf_flags", {30'd0, Carry, Overflow}, 32'b01);

        load_a(16'h0003); load_b(16'h0005);
        run_wait(1'b1); check("acc1", {A_out, Result}, 32'h0008_0008);
        run_wait(1'b1); check("acc2", {A_out, Result}, 32'h000D_000D);
        run_wait(1'b1); check("acc3", {A_out, Result}, 32'h0012_0012);

        // Load_A and Run during settle are dropped
        load_a(16'h0001); load_b(16'h0002);
        e = predict(model_a, model_b, 1'b0); sb.push_back(e);
        @(posedge Clk); #1 Accumulate = 1'b0; Run = 1'b1;
        @(posedge Clk); #1 Run = 1'b0; Din = 16'hAAAA; Load_A = 1'b1;
        @(posedge Clk); #1 Load_A = 1'b0; Run = 1'b1;
        @(posedge Clk); #1 Run = 1'b0;
        repeat (SETTLE + 4) @(posedge Clk); #1;
        check("busy_load_ignored", 32'(A_out), 32'h0001);
        check("busy_result", 32'(Result), 32'h0003);

        load_ab(16'h4001); run_wait(1'b0);

        // Load_B and Run on the same edge: add uses the new B
        @(posedge Clk); #1 Din = 16'h0100; Load_B = 1'b1; Run = 1'b1;
        model_b = 16'h0100;
        e = predict(model_a, model_b, 1'b0); sb.push_back(e);
        @(posedge Clk); #1 Load_B = 1'b0; Run = 1'b0;
        repeat (SETTLE + 3) @(posedge Clk); #1;
        check("load_run_same", 32'(Result), 32'h4101);

        back_to_back(1'b1);

        // Reset one cycle before capture aborts the add
        @(posedge Clk); #1 Run = 1'b1;
        @(posedge Clk); #1 Run = 1'b0;
        @(posedge Clk); #1 Reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_outs", {A_out, Result}, 32'd0);
        @(posedge Clk); #1 Reset_n = 1'b1;
        model_a = '0; model_b = '0;
        repeat (4) @(posedge Clk); #1;
        check("abort_idle_busy", {30'd0, Busy, Done}, 32'd0);
        check("abort_idle_vals", {B_out, Result}, 32'd0);
        check("abort_idle_flags", {30'd0, Carry, Overflow}, 32'd0);
        load_a(16'h0010); load_b(16'h0020); run_wait(1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: load_a(16'($urandom));
                1: load_b(16'($urandom));
                2: begin load_a(16'($urandom)); load_b(16'($urandom)); end
                default: load_ab(16'($urandom));
            endcase
            if ($urandom_range(0, 3) == 0) back_to_back(1'($urandom));
            else run_wait(1'($urandom));
        end

        repeat (SETTLE + 4) @(posedge Clk); #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_operand_sequencer.md
Name: adder_operand_sequencer

Overview:
Sequential front/back-end for the 16-bit carry-ripple adder. Holds operands A and B loaded from the switch bus and drives them onto the adder. On a Run press, waits a fixed number of settle cycles for the ripple chain, then registers Sum/CO plus a signed-overflow flag. Optional accumulate mode feeds the captured sum back into A for repeated addition.

Parameters:
WIDTH, 16, operand/result width; must match the adder width
SETTLE_CYCLES, 2, clock cycles allowed for ripple propagation before capture; legal range 1..15

Ports:
Clk  input  1  system clock, rising-edge active
Reset_n  input  1  asynchronous, active-low reset
Din  input  WIDTH  switch data bus, operand source
Load_A  input  1  level button; rising edge loads Din into A register
Load_B  input  1  level button; rising edge loads Din into B register
Run  input  1  level button; rising edge starts an add
Accumulate  input  1  level; sampled at capture; 1 = write captured sum back into A
Sum_in  input  WIDTH  sum returned from the adder
CO_in  input  1  carry-out returned from the adder
A_out  output  WIDTH  registered operand A to the adder
B_out  output  WIDTH  registered operand B to the adder
Result  output  WIDTH  captured sum
Carry  output  1  captured carry-out
Overflow  output  1  captured two's-complement overflow
Busy  output  1  high while settling
Done  output  1  one-cycle pulse on the cycle after capture

Behaviour:
- Reset (async, Reset_n=0): A_out=0, B_out=0, Result=0, Carry=0, Overflow=0, Busy=0, Done=0, state=IDLE, settle counter=0. Button-history registers are set to 1, so a button held through reset never produces an edge.
- Edge detect: each button has a one-cycle history register. An edge is current=1 and history=0, sampled at the clock edge. Inputs are treated as already synchronous.
- States: IDLE, SETTLE.
- IDLE:
  - Load_A edge: A_out<=Din. Load_B edge: B_out<=Din. Both edges on the same cycle: both load the same Din.
  - Run edge: state<=SETTLE, counter<=0, Busy<=1.
  - Load and Run edges on the same cycle: the loads take effect, and the add uses the new operands.
- SETTLE:
  - Counter increments each edge.
  - When counter==SETTLE_CYCLES-1 at an edge:
    - Result<=Sum_in, Carry<=CO_in.
    - Overflow<=(A_out[WIDTH-1]==B_out[WIDTH-1]) && (Sum_in[WIDTH-1]!=A_out[WIDTH-1]).
    - If Accumulate=1: A_out<=Sum_in.
    - Busy<=0, Done<=1, state<=IDLE.
- Latency: if the Run edge is captured at edge t0, capture occurs at edge t0+SETTLE_CYCLES. Busy is high for SETTLE_CYCLES cycles. Done is high exactly the cycle after capture.
- Loads and Run edges arriving during SETTLE are ignored and not queued. History registers still update, so a button held across Busy's fall never fires.
- Done deasserts on the next edge unconditionally. A new Run edge in the cycle Done is high is accepted normally.
- Overflow and Carry hold their values until the next capture or reset.
- Arithmetic is unsigned wrap for Result; Carry is the unsigned overflow indicator and Overflow the signed one. Both are independent.
- Reset asserted mid-SETTLE aborts immediately: no capture, and all outputs go to their reset values.

Test Plan:
- Reset with Run held high, release Reset_n, keep Run high 5 cycles -> Busy stays 0, Done never pulses, all outputs 0.
- Din=0x1234 Load_A edge, Din=0x0FF1 Load_B edge, Run edge, SETTLE_CYCLES=2 -> Busy high 2 cycles, then Result=0x2225, Carry=0, Overflow=0, single Done pulse.
- A=0xFFFF, B=0x0001, Run -> Result=0x0000, Carry=1, Overflow=0. Then A=0x7FFF, B=0x0001 -> Result=0x8000, Carry=0, Overflow=1.
- Accumulate=1, A=0x0003, B=0x0005, three Run presses -> Result 0x0008, 0x000D, 0x0012, with A_out tracking each result.
- Load_A edge with Din=0xAAAA during Busy -> A_out unchanged and the add result uses the old A. Run edge during Busy -> no second Done.
- Run edge then Reset_n low one cycle before capture -> Result=0, Done=0, Busy=0, and the state returns to IDLE.
